// File: rtl/mux_arb_pkg.sv
// Shared definitions for the 4-input round-robin select arbiter.
package mux_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [1:0] IDX_A0 = 2'b00;
  localparam logic [1:0] IDX_A1 = 2'b01;
  localparam logic [1:0] IDX_A2 = 2'b10;
  localparam logic [1:0] IDX_A3 = 2'b11;

  // One-hot grant pattern for a 2-bit requester index.
  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    logic [3:0] oh;
    oh = 4'b0000;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational rotating-priority picker: first set request scanning from ptr upward, wrapping at 3.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic       any,
  output logic [1:0] idx
);

  logic [1:0] cand;
  logic       found;

  // Scan the four rotated positions; the earliest set request wins.
  always_comb begin
    any   = |req;
    idx   = ptr;
    cand  = ptr;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cand = ptr + 2'(i);
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving a 4:1 select datapath with bounded hold per owner
// and a registered output operand.
module mux4_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] A0,
  input  logic [WIDTH-1:0] A1,
  input  logic [WIDTH-1:0] A2,
  input  logic [WIDTH-1:0] A3,
  output logic [3:0]       gnt,
  output logic             S0,
  output logic             S1,
  output logic [WIDTH-1:0] Y,
  output logic             Y_valid
);

  localparam int              HW        = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0]   HOLD_LAST = HW'(MAX_HOLD - 1);

  state_t        state, state_nx;
  logic [1:0]    ptr, ptr_nx;
  logic [1:0]    own, own_nx;
  logic [HW-1:0] hold_cnt, hold_nx;
  logic [3:0]    gnt_nx;
  logic [3:0]    others;
  logic          any_all, any_oth;
  logic [1:0]    idx_all, idx_oth;

  // The select registers double as the owner index; they keep their value while idle.
  assign S0 = own[1];
  assign S1 = own[0];

  assign others = req & ~onehot4(own);

  rr_pick4 u_pick_all (
    .req (req),
    .ptr (ptr),
    .any (any_all),
    .idx (idx_all)
  );

  rr_pick4 u_pick_oth (
    .req (others),
    .ptr (ptr),
    .any (any_oth),
    .idx (idx_oth)
  );

  // Next-state logic: grant, early handoff, forced rotation on hold expiry, or release to idle.
  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    own_nx   = own;
    hold_nx  = hold_cnt;
    gnt_nx   = gnt;
    case (state)
      IDLE: begin
        gnt_nx = 4'b0000;
        if (any_all) begin
          state_nx = BUSY;
          own_nx   = idx_all;
          gnt_nx   = onehot4(idx_all);
          hold_nx  = '0;
          ptr_nx   = idx_all + 2'd1;
        end
      end
      BUSY: begin
        if (!req[own]) begin
          if (any_oth) begin
            own_nx  = idx_oth;
            gnt_nx  = onehot4(idx_oth);
            hold_nx = '0;
            ptr_nx  = idx_oth + 2'd1;
          end else begin
            state_nx = IDLE;
            gnt_nx   = 4'b0000;
          end
        end else if (any_oth && (hold_cnt == HOLD_LAST)) begin
          own_nx  = idx_oth;
          gnt_nx  = onehot4(idx_oth);
          hold_nx = '0;
          ptr_nx  = idx_oth + 2'd1;
        end else if (hold_cnt != HOLD_LAST) begin
          hold_nx = hold_cnt + HW'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        gnt_nx   = 4'b0000;
      end
    endcase
  end

  // Control registers: FSM state, pointer, owner/select, hold counter and grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= 2'b00;
      own      <= IDX_A0;
      hold_cnt <= '0;
      gnt      <= 4'b0000;
    end else begin
      state    <= state_nx;
      ptr      <= ptr_nx;
      own      <= own_nx;
      hold_cnt <= hold_nx;
      gnt      <= gnt_nx;
    end
  end

  // Output stage: register the operand chosen by the current select; hold Y while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      Y       <= '0;
      Y_valid <= 1'b0;
    end else begin
      Y_valid <= |gnt;
      if (|gnt) begin
        case (own)
          IDX_A0:  Y <= A0;
          IDX_A1:  Y <= A1;
          IDX_A2:  Y <= A2;
          default: Y <= A3;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: directed scenarios plus randomized
// traffic against a behavioural round-robin model.
module tb_mux4_rr_arbiter;

  localparam int WIDTH    = 4;
  localparam int MAX_HOLD = 4;

  logic             clk;
  logic             rst;
  logic [3:0]       req;
  logic [WIDTH-1:0] a [4];
  logic [3:0]       gnt;
  logic             S0, S1;
  logic [WIDTH-1:0] Y;
  logic             Y_valid;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  bit               m_busy;
  int               m_own, m_ptr, m_hold;
  logic [3:0]       e_gnt;
  logic [1:0]       e_sel;
  logic [WIDTH-1:0] e_y;
  logic             e_yv;

  mux4_rr_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .A0      (a[0]),
    .A1      (a[1]),
    .A2      (a[2]),
    .A3      (a[3]),
    .gnt     (gnt),
    .S0      (S0),
    .S1      (S1),
    .Y       (Y),
    .Y_valid (Y_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // First requester found scanning p, p+1, p+2, p+3 (mod 4); -1 if none.
  function automatic int winner(input logic [3:0] r, input int p);
    for (int i = 0; i < 4; i++)
      if (r[(p + i) % 4]) return (p + i) % 4;
    return -1;
  endfunction

  task automatic model_grant(input int w);
    m_busy = 1;
    m_own  = w;
    m_hold = 0;
    m_ptr  = (w + 1) % 4;
    e_gnt  = 4'(1 << w);
    e_sel  = 2'(w);
  endtask

  // Update the model with the inputs presented to this edge, then step past the edge.
  task automatic advance();
    logic [3:0] oth;
    int w;
    if (rst) begin
      m_busy = 0; m_own = 0; m_ptr = 0; m_hold = 0;
      e_gnt = 4'b0000; e_sel = 2'b00; e_y = '0; e_yv = 1'b0;
    end else begin
      if (e_gnt != 4'b0000) e_y = a[e_sel];
      e_yv = (e_gnt != 4'b0000);
      if (!m_busy) begin
        w = winner(req, m_ptr);
        if (w >= 0) model_grant(w);
      end else begin
        oth = req;
        oth[m_own] = 1'b0;
        if (!req[m_own]) begin
          w = winner(oth, m_ptr);
          if (w >= 0) model_grant(w);
          else begin
            m_busy = 0;
            e_gnt  = 4'b0000;
          end
        end else if (oth != 4'b0000 && m_hold == MAX_HOLD - 1) begin
          model_grant(winner(oth, m_ptr));
        end else if (m_hold < MAX_HOLD - 1) begin
          m_hold = m_hold + 1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a[0] = 4'h5; a[1] = 4'h6; a[2] = 4'h7; a[3] = 4'h8;
    rst = 1'b1; req = 4'b1111;
    advance(); advance();
    n_checks++;
    if ({gnt, S0, S1, Y, Y_valid} !== {4'b0000, 2'b00, 4'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_vals: got gnt=%b sel=%b%b Y=%h v=%b, want gnt=0000 sel=00 Y=0 v=0", gnt, S0, S1, Y, Y_valid);
    end
    rst = 1'b0;
    advance();
    n_checks++;
    if ({gnt, S0, S1, Y_valid} !== {4'b0001, 2'b00, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_first_grant: got gnt=%b sel=%b%b v=%b, want gnt=0001 sel=00 v=0", gnt, S0, S1, Y_valid);
    end
    advance();
    n_checks++;
    if ({Y, Y_valid} !== {4'h5, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_first_data: got Y=%h v=%b, want Y=5 v=1", Y, Y_valid);
    end
  endtask

  task automatic test_sole();
    rst = 1'b1; req = 4'b0000;
    advance();
    rst = 1'b0; req = 4'b0100; a[2] = 4'hC;
    for (int i = 0; i < 10; i++) begin
      advance();
      n_checks++;
      if ({gnt, S0, S1} !== {4'b0100, 2'b10} || Y_valid !== (i >= 1) || (i >= 1 && Y !== 4'hC)) begin
        n_fail++;
        $display("FAIL sole_cyc%0d: got gnt=%b sel=%b%b Y=%h v=%b, want gnt=0100 sel=10 Y=C v=%0d", i, gnt, S0, S1, Y, Y_valid, (i >= 1));
      end
    end
  endtask

  task automatic test_fairness();
    logic [3:0] want;
    rst = 1'b1; req = 4'b1111;
    advance();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      a[0] = 4'(i); a[1] = 4'(i + 3); a[2] = 4'(i + 7); a[3] = 4'(i + 11);
      advance();
      want = 4'(1 << ((i / MAX_HOLD) % 4));
      n_checks++;
      if (gnt !== want || Y_valid !== (i >= 1) || Y !== e_y) begin
        n_fail++;
        $display("FAIL fair_cyc%0d: got gnt=%b Y=%h v=%b, want gnt=%b Y=%h v=%0d", i, gnt, Y, Y_valid, want, e_y, (i >= 1));
      end
    end
  endtask

  task automatic test_early_release();
    rst = 1'b1; req = 4'b0000;
    advance();
    rst = 1'b0; req = 4'b0010;
    advance();
    req = 4'b1010;
    advance();
    n_checks++;
    if (gnt !== 4'b0010) begin
      n_fail++;
      $display("FAIL early_hold: got gnt=%b, want gnt=0010", gnt);
    end
    req = 4'b1000;
    advance();
    n_checks++;
    if ({gnt, S0, S1} !== {4'b1000, 2'b11} || Y_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL early_switch: got gnt=%b sel=%b%b v=%b, want gnt=1000 sel=11 v=1", gnt, S0, S1, Y_valid);
    end
    req = 4'b0000;
    advance();
    req = 4'b0110;
    advance();
    n_checks++;
    if (gnt !== 4'b0010) begin
      n_fail++;
      $display("FAIL early_ptr_wrap: got gnt=%b, want gnt=0010", gnt);
    end
  endtask

  task automatic test_last_leaves();
    rst = 1'b1; req = 4'b0000;
    advance();
    rst = 1'b0; req = 4'b1000; a[3] = 4'h9;
    advance(); advance();
    req = 4'b0000;
    advance();
    n_checks++;
    if ({gnt, S0, S1, Y, Y_valid} !== {4'b0000, 2'b11, 4'h9, 1'b1}) begin
      n_fail++;
      $display("FAIL leave_gnt: got gnt=%b sel=%b%b Y=%h v=%b, want gnt=0000 sel=11 Y=9 v=1", gnt, S0, S1, Y, Y_valid);
    end
    a[3] = 4'h2;
    advance();
    n_checks++;
    if ({Y, Y_valid} !== {4'h9, 1'b0}) begin
      n_fail++;
      $display("FAIL leave_data: got Y=%h v=%b, want Y=9 v=0", Y, Y_valid);
    end
  endtask

  task automatic test_mid_reset();
    rst = 1'b1; req = 4'b0000;
    advance();
    rst = 1'b0; req = 4'b0100; a[2] = 4'hE;
    advance(); advance(); advance();
    rst = 1'b1;
    advance();
    n_checks++;
    if ({gnt, S0, S1, Y, Y_valid} !== {4'b0000, 2'b00, 4'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL midrst_vals: got gnt=%b sel=%b%b Y=%h v=%b, want gnt=0000 sel=00 Y=0 v=0", gnt, S0, S1, Y, Y_valid);
    end
    rst = 1'b0; req = 4'b0110;
    advance();
    n_checks++;
    if ({gnt, S0, S1} !== {4'b0010, 2'b01}) begin
      n_fail++;
      $display("FAIL midrst_winner: got gnt=%b sel=%b%b, want gnt=0010 sel=01", gnt, S0, S1);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 2) == 0) req = 4'($urandom_range(0, 15));
      for (int k = 0; k < 4; k++) a[k] = 4'($urandom);
      advance();
      n_checks++;
      if ({gnt, S0, S1, Y, Y_valid} !== {e_gnt, e_sel, e_y, e_yv}) begin
        n_fail++;
        $display("FAIL random_cyc%0d: got gnt=%b sel=%b%b Y=%h v=%b, want gnt=%b sel=%b Y=%h v=%b",
                 i, gnt, S0, S1, Y, Y_valid, e_gnt, e_sel, e_y, e_yv);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b0000;
    for (int k = 0; k < 4; k++) a[k] = '0;
    m_busy = 0; m_own = 0; m_ptr = 0; m_hold = 0;
    e_gnt = 4'b0000; e_sel = 2'b00; e_y = '0; e_yv = 1'b0;
    test_reset();
    test_sole();
    test_fairness();
    test_early_release();
    test_last_leaves();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter and sequencer for the shared 4-input, WIDTH-bit select datapath. It accepts up to four requesters and grants the datapath to one of them at a time. It drives the two select lines, with S0 as the MSB and S1 as the LSB of the winner index. It registers the selected operand onto Y with a valid flag. It sits between requesting sources and downstream logic and enforces fairness with a bounded hold time per grant.

## Interface
- WIDTH, 4: data width of each input line and of Y.
- MAX_HOLD, 4: maximum consecutive grant cycles per owner while another requester waits; legal values are ≥1.
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous reset, active-high.
- req  input  4  request vector; bit i is requester i.
- A0, A1, A2, A3  input  WIDTH each  operand from requester 0/1/2/3.
- gnt  output  4  registered one-hot grant; all-zero when idle.
- S0  output  1  registered select MSB, equal to owner index bit 1.
- S1  output  1  registered select LSB, equal to owner index bit 0.
- Y  output  WIDTH  registered selected operand.
- Y_valid  output  1  Y carries data of a granted owner.

## Operation
- State machine with two states:
  - IDLE: no owner.
  - BUSY: owner index `own` holds the grant.
- Round-robin priority:
  - A rotating pointer `ptr` (2 bits) names the highest-priority requester.
  - The winner is the first set bit of req scanning ptr, ptr+1, ptr+2, ptr+3, modulo 4.
  - After any grant to index k, ptr becomes (k+1) mod 4; index 3 wraps to 0.
- IDLE:
  - If req≠0, go to BUSY with own = winner, gnt = one-hot(winner), {S0,S1} = winner, and hold_cnt = 0.
  - Otherwise stay in IDLE.
- BUSY: let `others` be the requests of every index except own.
  - req[own]=0 and others≠0: switch directly to the winner among others. No idle cycle; hold_cnt = 0.
  - req[own]=0 and others=0: go to IDLE; gnt=0; S0/S1 keep their last value.
  - req[own]=1, others≠0, and hold_cnt == MAX_HOLD-1: rotate to the winner among others.
  - Otherwise keep own and increment hold_cnt, saturating at MAX_HOLD-1.
- With a sole requester, the grant is held indefinitely.
- MAX_HOLD=1 under contention rotates the grant every cycle.
- Datapath, each cycle:
  - Y <= operand selected by the current registered {S0,S1}.
  - Y_valid <= |gnt.
  - When gnt=0, Y holds its value and Y_valid goes to 0.
- Width rules:
  - hold_cnt is max(1, clog2(MAX_HOLD)) bits wide.
  - Y is exactly WIDTH bits with no extension.
- Reset values:
  - state=IDLE, ptr=0, hold_cnt=0.
  - gnt=4'b0000, S0=0, S1=0, Y=0, Y_valid=0.
- Reset has priority over every other event, including mid-grant. The cycle after rst deasserts behaves as IDLE with ptr=0.
- Requests are level-sensitive. No acknowledge is needed beyond gnt, and a requester may drop req at any cycle.

## Timing
- Latency:
  - req sampled at edge n gives gnt/S0/S1 valid after edge n.
  - Y/Y_valid for that owner are valid after edge n+1.
  - Request to data is 2 cycles.
- Owner switch on edge m: gnt/S0/S1 change at m; Y shows the new operand after m+1. There is no bubble in Y_valid.
- Dropping req at edge n removes gnt after edge n; Y_valid falls after edge n+1.
- Under full contention, each owner gets exactly MAX_HOLD consecutive cycles. Worst-case wait is 3·MAX_HOLD cycles.

## Structure
- Shared package or header `mux_arb_pkg`:
  - State encoding (IDLE=0, BUSY=1).
  - Index constants IDX_A0..IDX_A3 = 2'b00..2'b11.
  - Function onehot4(idx).
- Sub-module `rr_pick4`: combinational rotating-priority picker.
  - Inputs: req[3:0], ptr[1:0].
  - Outputs: any, idx[1:0].
  - Instantiated twice: once with the full req, once with others.
- The top holds the FSM, pointer, hold counter, select registers, and the output register/mux.

## Test plan
- Reset: assert rst with req=4'b1111, then release → gnt=4'b0001 and {S0,S1}=00 one cycle later; Y=A0 one cycle after that.
- Sole requester: req=4'b0100 held 10 cycles, A2=4'hC → gnt stays 4'b0100 and {S0,S1}=10 throughout; Y=4'hC with Y_valid=1 from cycle 2 on.
- Fairness: MAX_HOLD=4, req=4'b1111 held 20 cycles → grants go 0,1,2,3,0 in 4-cycle blocks; Y_valid never drops.
- Early release: owner 1 drops req while req[3]=1 → gnt goes 4'b0010→4'b1000 on the next edge with no idle cycle; ptr wraps to 0.
- Last requester leaves: only owner drops req → gnt=0 next edge, Y_valid=0 one edge later, Y retains its last value.
- Mid-grant reset: rst pulsed with owner 2 at hold_cnt=2 → all outputs at reset values next edge; after release with req=4'b0110, requester 1 wins.
